match_ctrl: RTL



---
 rtl/match_pkg.sv | 29 ++
 rtl/btn_debounce.sv | 55 +++++
 rtl/match_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/match_pkg.sv
// Shared types and constants for the match controller: FSM states, winner codes
// and the win-condition helper used on the freshly updated scores.
package match_pkg;

    localparam int SCORE_W = 7;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 7'd99;

    typedef enum logic {
        PLAY = 1'b0,
        WIN  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_e;

    // True when 'own' has won against 'other': the hard cap, or the target with a 2-point lead.
    function automatic logic is_win(input logic [SCORE_W-1:0] own,
                                    input logic [SCORE_W-1:0] other,
                                    input logic [SCORE_W-1:0] win_points);
        logic [7:0] diff;
        diff = {1'b0, own} - {1'b0, other};
        return (own == SCORE_MAX) ||
               ((own >= win_points) && (own > other) && (diff >= 8'd2));
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: two-flop synchronizer, stability counter, accepted level
// and a one-cycle pulse on each accepted rising edge.
module btn_debounce #(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic rise_o
);

    localparam int CNT_W = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: two flops before any use of the raw button; the first one may go metastable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/match_ctrl.sv
// Game controller: debounced point events, tie arbitration with one pending
// point, score/serve bookkeeping and the PLAY/WIN sequencing with winner blink.
module match_ctrl
    import match_pkg::*;
#(
    parameter int WIN_POINTS  = 11,
    parameter int DEBOUNCE_MS = 20,
    parameter int WIN_HOLD_MS = 5000,
    parameter int BLINK_MS    = 250
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               p1_btn_i,
    input  logic               p2_btn_i,
    output logic [SCORE_W-1:0] score_p1_o,
    output logic [SCORE_W-1:0] score_p2_o,
    output logic               serve_o,
    output logic [1:0]         winner_o,
    output logic               blank_o
);

    localparam int HOLD_W  = $clog2(WIN_HOLD_MS);
    localparam int BLINK_W = $clog2(BLINK_MS);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(WIN_HOLD_MS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_MS - 1);
    localparam logic [SCORE_W-1:0] WIN_PTS    = SCORE_W'(WIN_POINTS);
    localparam logic [SCORE_W-1:0] DEUCE_PTS  = SCORE_W'(WIN_POINTS - 1);

    logic ev1, ev2;

    btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_deb_p1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (p1_btn_i),
        .rise_o (ev1)
    );

    btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_deb_p2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (p2_btn_i),
        .rise_o (ev2)
    );

    state_e               state_q, state_d;
    winner_e              winner_q, winner_d;
    logic [SCORE_W-1:0]   score1_q, score1_d, score2_q, score2_d;
    logic [SCORE_W-1:0]   s1_new, s2_new;
    logic                 serve_q, serve_d, first_serve_q, first_serve_d;
    logic                 parity_q, parity_d;
    logic                 blank_q, blank_d;
    logic                 pend_q, pend_d, pend_p2_q, pend_p2_d;
    logic                 last_p2_q, last_p2_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [BLINK_W-1:0]   blink_q, blink_d;
    logic                 add1, add2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= PLAY;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            winner_q      <= WIN_NONE;
            score1_q      <= '0;
            score2_q      <= '0;
            serve_q       <= 1'b0;
            first_serve_q <= 1'b0;
            parity_q      <= 1'b0;
            blank_q       <= 1'b0;
            pend_q        <= 1'b0;
            pend_p2_q     <= 1'b0;
            last_p2_q     <= 1'b1;
            hold_q        <= '0;
            blink_q       <= '0;
        end else begin
            winner_q      <= winner_d;
            score1_q      <= score1_d;
            score2_q      <= score2_d;
            serve_q       <= serve_d;
            first_serve_q <= first_serve_d;
            parity_q      <= parity_d;
            blank_q       <= blank_d;
            pend_q        <= pend_d;
            pend_p2_q     <= pend_p2_d;
            last_p2_q     <= last_p2_d;
            hold_q        <= hold_d;
            blink_q       <= blink_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        winner_d      = winner_q;
        score1_d      = score1_q;
        score2_d      = score2_q;
        serve_d       = serve_q;
        first_serve_d = first_serve_q;
        parity_d      = parity_q;
        blank_d       = blank_q;
        pend_d        = pend_q;
        pend_p2_d     = pend_p2_q;
        last_p2_d     = last_p2_q;
        hold_d        = '0;
        blink_d       = '0;
        add1          = 1'b0;
        add2          = 1'b0;

        // The deferred point is not a fresh grant, so last-grant keeps the tie winner
        // and back-to-back ties alternate.
        if (state_q == PLAY) begin
            if (pend_q) begin
                add1      = !pend_p2_q;
                add2      = pend_p2_q;
                pend_d    = pend_p2_q ? ev1 : ev2;
                pend_p2_d = !pend_p2_q;
            end else if (ev1 && ev2) begin
                add1      = last_p2_q;
                add2      = !last_p2_q;
                pend_d    = 1'b1;
                pend_p2_d = last_p2_q;
                last_p2_d = !last_p2_q;
            end else if (ev1) begin
                add1      = 1'b1;
                last_p2_d = 1'b0;
            end else if (ev2) begin
                add2      = 1'b1;
                last_p2_d = 1'b1;
            end
        end

        s1_new = score1_q + SCORE_W'(add1 && (score1_q != SCORE_MAX));
        s2_new = score2_q + SCORE_W'(add2 && (score2_q != SCORE_MAX));

        if (state_q == PLAY) begin
            if (add1 || add2) begin
                score1_d = s1_new;
                score2_d = s2_new;
                parity_d = !parity_q;
                if (parity_q || ((s1_new >= DEUCE_PTS) && (s2_new >= DEUCE_PTS)))
                    serve_d = !serve_q;
                if (is_win(s1_new, s2_new, WIN_PTS)) begin
                    winner_d = WIN_P1;
                    state_d  = WIN;
                    pend_d   = 1'b0;
                end else if (is_win(s2_new, s1_new, WIN_PTS)) begin
                    winner_d = WIN_P2;
                    state_d  = WIN;
                    pend_d   = 1'b0;
                end
            end
        end else begin
            pend_d = 1'b0;
            hold_d = hold_q + HOLD_W'(1);
            if (blink_q == BLINK_LAST) begin
                blank_d = !blank_q;
            end else begin
                blink_d = blink_q + BLINK_W'(1);
            end
            if (hold_q == HOLD_LAST) begin
                state_d       = PLAY;
                winner_d      = WIN_NONE;
                score1_d      = '0;
                score2_d      = '0;
                blank_d       = 1'b0;
                parity_d      = 1'b0;
                serve_d       = !first_serve_q;
                first_serve_d = !first_serve_q;
                hold_d        = '0;
                blink_d       = '0;
            end
        end
    end

    always_comb begin
        score_p1_o = score1_q;
        score_p2_o = score2_q;
        serve_o    = serve_q;
        winner_o   = winner_q;
        blank_o    = blank_q;
    end

endmodule
